// File: rtl/ps2_pkg.sv
// Shared byte constants, decoder state encoding and event word layout for the PS/2 scancode path.
// Latency: none (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  // Set-2 prefix bytes
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;

  // Device status / reply bytes that never represent a key in IDLE
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;

  // Decoder state: which prefixes of the current sequence have been seen
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  // 10-bit event word {ext, brk, code}
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  localparam int PS2_EVENT_W = $bits(ps2_event_t);

  // True for bytes the keyboard sends as status rather than as a key code
  function automatic logic ps2_is_status(input logic [7:0] b);
    return (b == PS2_BAT)    || (b == PS2_ACK)  || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1) ||
           (b == PS2_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead FIFO: head word driven straight from storage, full/empty flags.
// Latency: a push is visible at the head the cycle after the write edge when empty.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO can still take a word when the head leaves on the same edge
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// Turns the PS/2 receiver byte stream into key events (E0/F0 prefixes, status filtering, timeout).
// Latency: event at the FIFO head one cycle after the completing byte's rx_done edge.
// Backpressure: ev_valid/ev_ready; events arriving while the FIFO is full are dropped and ovf sticks.
module ps2_scancode_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       ovf,
  output logic       err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_t state;
  ps2_state_t state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          proto_err;
  logic          push_vld;
  ps2_event_t    push_dat;
  ps2_event_t    head_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  assign ev_valid = !fifo_empty;
  assign pop      = ev_valid && ev_ready;
  assign ev_code  = head_dat.code;
  assign ev_break = head_dat.brk;
  assign ev_ext   = head_dat.ext;

  // A partial sequence expires only when no byte arrives on that cycle
  assign tmo_hit = (state != ST_IDLE) && !rx_done && (tmo_cnt == TMO_LAST);

  // Byte decode: next state, event to push and protocol error for this cycle
  always_comb begin
    state_nxt     = state;
    push_vld      = 1'b0;
    push_dat.ext  = 1'b0;
    push_dat.brk  = 1'b0;
    push_dat.code = rx_data;
    proto_err     = 1'b0;
    if (rx_done) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == PS2_EXT)       state_nxt = ST_EXT;
          else if (rx_data == PS2_BRK)  state_nxt = ST_BRK;
          else if (!ps2_is_status(rx_data)) push_vld = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else if (rx_data == PS2_EXT) begin
            // Repeated E0 is flagged but the extended prefix is kept
            proto_err = 1'b1;
          end else begin
            push_vld     = 1'b1;
            push_dat.ext = 1'b1;
            state_nxt    = ST_IDLE;
          end
        end
        ST_BRK: begin
          state_nxt = ST_IDLE;
          if (rx_data == PS2_EXT || rx_data == PS2_BRK) begin
            proto_err = 1'b1;
          end else begin
            push_vld     = 1'b1;
            push_dat.brk = 1'b1;
          end
        end
        ST_EXT_BRK: begin
          state_nxt = ST_IDLE;
          if (rx_data == PS2_EXT || rx_data == PS2_BRK) begin
            proto_err = 1'b1;
          end else begin
            push_vld     = 1'b1;
            push_dat.brk = 1'b1;
            push_dat.ext = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nxt = ST_IDLE;
    end
  end

  // Decoder state, timeout counter and registered err/ovf flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
      err     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= proto_err || tmo_hit;
      if (push_vld && fifo_full && !pop) ovf <= 1'b1;
      if (rx_done || state == ST_IDLE || tmo_hit) tmo_cnt <= '0;
      else                                        tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  ps2_event_fifo #(
    .WIDTH (PS2_EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_vld),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Directed bench for ps2_scancode_ctrl with a short timeout and a 4-entry FIFO.
// Latency: inputs change and outputs are sampled on the falling edge.
// Backpressure: ev_ready driven explicitly per step.
module tb_ps2_scancode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;
  logic       ovf;
  logic       err;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] fill [5];

  always #5 clk = ~clk;

  ps2_scancode_ctrl #(
    .TIMEOUT_CYCLES (100),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_break (ev_break),
    .ev_ext   (ev_ext),
    .ovf      (ovf),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte strobe; returns on the falling edge after it was sampled
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [7:0] code, input logic brk, input logic ext);
    check({tag, "_valid"}, ev_valid, 1);
    check({tag, "_code"},  ev_code,  code);
    check({tag, "_break"}, ev_break, brk);
    check({tag, "_ext"},   ev_ext,   ext);
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_done  = 1'b0;
    ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", ev_valid, 0);
    check("rst_code",  ev_code,  0);
    check("rst_break", ev_break, 0);
    check("rst_ext",   ev_ext,   0);
    check("rst_ovf",   ovf,      0);
    check("rst_err",   err,      0);
    rst = 1'b0;

    // Plain make code, consumer ready: visible one cycle later, gone the next
    ev_ready = 1'b1;
    send(8'h1C);
    check_head("make1c", 8'h1C, 0, 0);
    @(negedge clk);
    check("make1c_popped", ev_valid, 0);
    ev_ready = 1'b0;

    // Break, extended break, extended make
    send(8'hF0);
    check("f0_no_event", ev_valid, 0);
    send(8'h1C);
    check_head("brk1c", 8'h1C, 1, 0);
    pop_one();
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    check_head("extbrk74", 8'h74, 1, 1);
    pop_one();
    send(8'hE0);
    send(8'h75);
    check_head("ext75", 8'h75, 0, 1);
    pop_one();
    check("seq_empty", ev_valid, 0);

    // Overflow: five back-to-back makes into a 4-deep FIFO
    fill[0] = 8'h15; fill[1] = 8'h1D; fill[2] = 8'h24; fill[3] = 8'h2D; fill[4] = 8'h2C;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx_data = fill[i];
      rx_done = 1'b1;
      if (i == 4) check("ovf_before_fifth", ovf, 0);
    end
    @(negedge clk);
    rx_done = 1'b0;
    check("ovf_after_fifth", ovf, 1);
    for (int i = 0; i < 4; i++) begin
      check_head("drain", fill[i], 0, 0);
      pop_one();
    end
    check("drain_empty", ev_valid, 0);
    check("ovf_sticky", ovf, 1);

    // Push and pop together at full: nothing dropped, ovf stays clear
    pulse_rst();
    check("ovf_cleared", ovf, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_data = fill[i];
      rx_done = 1'b1;
    end
    @(negedge clk);
    rx_data  = 8'h3C;
    rx_done  = 1'b1;
    ev_ready = 1'b1;
    @(negedge clk);
    rx_done  = 1'b0;
    ev_ready = 1'b0;
    check("pushpop_ovf", ovf, 0);
    check_head("pushpop_h0", 8'h1D, 0, 0);
    pop_one();
    check_head("pushpop_h1", 8'h24, 0, 0);
    pop_one();
    check_head("pushpop_h2", 8'h2D, 0, 0);
    pop_one();
    check_head("pushpop_h3", 8'h3C, 0, 0);
    pop_one();
    check("pushpop_empty", ev_valid, 0);

    // Timeout: E0 then silence; err exactly 100 cycles after the E0 edge
    send(8'hE0);
    repeat (99) @(negedge clk);
    check("tmo_err_early", err, 0);
    @(negedge clk);
    check("tmo_err_pulse", err, 1);
    @(negedge clk);
    check("tmo_err_clear", err, 0);
    check("tmo_no_event", ev_valid, 0);
    send(8'h1C);
    check_head("tmo_after", 8'h1C, 0, 0);
    pop_one();

    // Status bytes in IDLE are silently discarded
    send(8'hAA);
    check("aa_err", err, 0);
    send(8'hFA);
    check("fa_err", err, 0);
    send(8'hFF);
    check("ff_err", err, 0);
    check("status_no_event", ev_valid, 0);

    // F0 F0: error, back to IDLE
    send(8'hF0);
    send(8'hF0);
    check("f0f0_err", err, 1);
    check("f0f0_no_event", ev_valid, 0);
    @(negedge clk);
    check("f0f0_err_one_cycle", err, 0);
    send(8'h1C);
    check_head("f0f0_idle", 8'h1C, 0, 0);
    pop_one();

    // E0 E0: error, stays extended
    send(8'hE0);
    send(8'hE0);
    check("e0e0_err", err, 1);
    send(8'h70);
    check("e0e0_err_clear", err, 0);
    check_head("e0e0_ext70", 8'h70, 0, 1);
    pop_one();

    // Reset mid-sequence with a queued event
    send(8'h15);
    send(8'hE0);
    pulse_rst();
    check("midrst_valid", ev_valid, 0);
    check("midrst_err", err, 0);
    check("midrst_ovf", ovf, 0);
    send(8'h1C);
    check_head("midrst_1c", 8'h1C, 0, 0);
    check("midrst_err_after", err, 0);
    pop_one();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_ctrl.md
# ps2_scancode_ctrl

Sequences the byte stream produced by the PS/2 receiver (8-bit byte plus one-cycle done pulse) into complete key events. Decodes Set-2 prefixes (E0 extended, F0 break) and discards device status bytes. Guards partial sequences with a timeout and buffers events in a small FIFO with a valid/ready handshake toward the key-mapping logic.

## Interface
- TIMEOUT_CYCLES, 2_500_000, clk cycles without a byte before a partial prefix sequence is abandoned (50 ms at 50 MHz); minimum 2
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16
- clk  in  1  system clock; every register updates on its rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  byte from the PS/2 receiver; valid only while rx_done=1
- rx_done  in  1  one-cycle strobe; each high cycle is exactly one byte
- ev_valid  out  1  FIFO not empty
- ev_ready  in  1  consumer accepts the head event when ev_valid&ev_ready
- ev_code  out  8  scancode of the head event
- ev_break  out  1  head event is a release
- ev_ext  out  1  head event carried the E0 prefix
- ovf  out  1  sticky: an event was dropped because the FIFO was full; cleared only by rst
- err  out  1  one-cycle pulse on a protocol error or timeout

## Operation
- Reset: FSM=IDLE, FIFO empty, ev_valid=0, ev_code=0, ev_break=0, ev_ext=0, ovf=0, err=0, timeout counter=0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions occur only on rx_done or timeout.
- IDLE: E0->EXT; F0->BRK; AA, FA, EE, FE, 00, FF, E1 -> discarded, stay IDLE, no err; any other byte -> push {code, brk=0, ext=0}.
- EXT: F0->EXT_BRK; E0 -> err pulse, stay EXT; any other byte -> push {code, 0, 1}, go IDLE.
- BRK: E0 or F0 -> err pulse, IDLE, no push; other -> push {code, 1, 0}, IDLE.
- EXT_BRK: E0 or F0 -> err pulse, IDLE; other -> push {code, 1, 1}, IDLE.
- Status bytes (AA, FA, ...) in a non-IDLE state are treated as codes; no special filtering there.
- Timeout: counter clears on every rx_done and while in IDLE; otherwise increments. When it reaches TIMEOUT_CYCLES-1: FSM->IDLE, err pulse, counter clears.
- rx_done coincident with the timeout cycle: the byte wins, timeout is ignored.
- FIFO: show-ahead, head presented combinationally from storage registers; pop on ev_valid&ev_ready.
- Push when full with no pop: event dropped, ovf set. Push and pop in the same cycle when full: both happen, count unchanged, no ovf. Push and pop when empty: not possible (ev_valid=0), push only.
- Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- rst mid-sequence abandons any prefix and empties the FIFO without an err pulse.

## Timing
- Byte sampled at edge k (rx_done=1) -> FSM/FIFO updated at edge k -> ev_valid high from the cycle after k if FIFO was empty: 1-cycle latency.
- err asserts in the cycle after the triggering edge, for exactly one cycle.
- Back-to-back rx_done on consecutive cycles is supported: one byte per cycle throughput.
- Events leave in arrival order; ev_code/ev_break/ev_ext stable while ev_valid=1 and ev_ready=0.

## Structure
- Shared package ps2_pkg: byte constants PS2_EXT=E0, PS2_BRK=F0, PS2_BAT=AA, PS2_ACK=FA, PS2_ECHO=EE, PS2_RESEND=FE, PS2_ERR0=00, PS2_ERR1=FF, PS2_PAUSE=E1; FSM state encoding; 10-bit event word layout {ext, brk, code[7:0]}.
- One sub-module: ps2_event_fifo (parameterised width/depth, sync reset, full/empty, show-ahead) instantiated with width 10.
- Decoder FSM and timeout counter live in the top module.

## Test plan
- rx 1C, ev_ready=1 -> one cycle later ev_valid=1, ev_code=1C, ev_break=0, ev_ext=0; popped next edge, ev_valid=0.
- rx F0, 1C -> single event 1C break=1 ext=0; rx E0, F0, 74 -> 74 break=1 ext=1; rx E0, 75 -> 75 break=0 ext=1.
- ev_ready=0, rx 15,1D,24,2D,2C (DEPTH=4) -> ovf=1 after fifth, drain yields 15,1D,24,2D; push+pop on same cycle at full leaves ovf clear.
- TIMEOUT_CYCLES=100: rx E0 then idle 100 cycles -> err pulse, no event; next rx 1C -> plain event ext=0.
- rx AA, FA, FF in IDLE -> no event, no err; rx F0, F0 -> err pulse, IDLE; rx E0, E0 -> err, still EXT, then 70 -> ext=1 event.
- rx E0, assert rst one cycle, rx 1C -> FIFO emptied, event 1C ext=0, ovf=0, no err.
